contador_reader: RTL and testbench

Readout sequencer that sits beside the pop-counter block (`contadores`) and drives its read port. When the system is idle and a `start` pulse arrives, it walks `idx` over the five counters (FIFO0–FIFO3 and FIFO4). For each counter it holds `req` high, captures the returned 5-bit `data` on `valid`, and packs all five counts into one result bus, with a `done` pulse at the end. A per-slot timeout keeps a silent counter block from hanging the sequence.

---
 rtl/contador_reader_if.sv | 16 +
 rtl/contador_reader.sv | 134 +++++++++++++
 tb/tb_contador_reader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/contador_reader_if.sv
// Read port between contador_reader (master) and the pop-counter block (slave).
// Handshake: the master holds req high while addressing idx. The slave raises valid with
// data for that idx no earlier than the cycle after idx changes. The master captures
// data on any WAIT edge where valid is high, then moves idx on.
interface contador_reader_if #(
  parameter int CNT_W = 5,
  parameter int IDX_W = 3
);
  logic             req;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] data;
  logic             valid;

  modport master (output req, idx, input data, valid);
  modport slave  (input req, idx, output data, valid);
endinterface

// File: rtl/contador_reader.sv
// Readout sequencer: walks idx over the pop counters, packs every count into cnt_all,
// and marks any slot that stays silent past TIMEOUT wait cycles in err.
module contador_reader #(
  parameter int NUM_CNT = 5,
  parameter int CNT_W   = 5,
  parameter int IDX_W   = 3,
  parameter int TIMEOUT = 8
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     IDLE,
  input  logic                     start,
  contador_reader_if.master        rd,
  output logic                     busy,
  output logic                     done,
  output logic                     abort,
  output logic [NUM_CNT*CNT_W-1:0] cnt_all,
  output logic [NUM_CNT-1:0]       err,
  output logic [1:0]               dbg_state
);

  localparam int               TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    T_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_CNT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                   state, state_d;
  logic [TW-1:0]            tcnt, tcnt_d;
  logic [IDX_W-1:0]         idx_d;
  logic                     req_d, busy_d, done_d, abort_d;
  logic [NUM_CNT*CNT_W-1:0] cnt_all_d;
  logic [NUM_CNT-1:0]       err_d;

  assign dbg_state = state;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      tcnt    <= '0;
      rd.req  <= 1'b0;
      rd.idx  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      abort   <= 1'b0;
      cnt_all <= '0;
      err     <= '0;
    end else begin
      state   <= state_d;
      tcnt    <= tcnt_d;
      rd.req  <= req_d;
      rd.idx  <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      abort   <= abort_d;
      cnt_all <= cnt_all_d;
      err     <= err_d;
    end
  end

  always_comb begin
    state_d   = state;
    tcnt_d    = tcnt;
    idx_d     = rd.idx;
    cnt_all_d = cnt_all;
    err_d     = err;
    abort_d   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && IDLE) begin
          state_d   = S_SETTLE;
          idx_d     = '0;
          cnt_all_d = '0;
          err_d     = '0;
        end
      end

      // valid may still describe the previous idx here, so it is not looked at.
      S_SETTLE: begin
        if (!IDLE) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else begin
          tcnt_d  = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!IDLE) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (rd.valid || (tcnt == T_LAST)) begin
          // valid takes priority over a timeout landing on the same edge.
          if (rd.valid) begin
            cnt_all_d[int'(rd.idx)*CNT_W +: CNT_W] = rd.data;
          end else begin
            err_d[rd.idx] = 1'b1;
          end
          if (rd.idx == I_LAST) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d   = rd.idx + 1'b1;
            state_d = S_SETTLE;
          end
        end else if (tcnt != T_LAST) begin
          tcnt_d = tcnt + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of the next-state decode.
    req_d  = (state_d == S_SETTLE) || (state_d == S_WAIT);
    busy_d = req_d;
    done_d = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_contador_reader.sv
// Bench for contador_reader: behavioural counter-block model on the read port, scoreboard
// of expected {err, cnt_all} checked on every done pulse, plus timing and abort/reset checks.
module tb_contador_reader;
  localparam int NUM_CNT = 5;
  localparam int CNT_W   = 5;
  localparam int IDX_W   = 3;
  localparam int TIMEOUT = 8;
  localparam int RW      = NUM_CNT * CNT_W;

  logic               CLK   = 1'b0;
  logic               reset = 1'b0;
  logic               IDLE  = 1'b1;
  logic               start = 1'b0;
  logic               busy, done, abort;
  logic [RW-1:0]      cnt_all;
  logic [NUM_CNT-1:0] err;
  logic [1:0]         dbg_state;

  contador_reader_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) rd ();

  contador_reader #(
    .NUM_CNT(NUM_CNT), .CNT_W(CNT_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .reset(reset), .IDLE(IDLE), .start(start), .rd(rd),
    .busy(busy), .done(done), .abort(abort), .cnt_all(cnt_all), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int idx2_cycles = 0;
  logic [RW+NUM_CNT-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- counter block model ----------------
  logic [CNT_W-1:0]   tbl [NUM_CNT];
  logic [NUM_CNT-1:0] silent = '0;
  logic               stale  = 1'b0;
  logic [IDX_W-1:0]   last_idx;
  logic               last_req;

  initial begin
    rd.valid = 1'b0;
    rd.data  = '0;
    last_idx = '0;
    last_req = 1'b0;
    forever begin
      @(negedge CLK);
      if (stale) begin
        // valid never drops; data lags one cycle behind an idx change
        rd.valid = rd.req;
        rd.data  = (rd.idx != last_idx) ? tbl[last_idx] : tbl[rd.idx];
      end else begin
        rd.valid = rd.req && last_req && (rd.idx == last_idx) && !silent[rd.idx];
        rd.data  = rd.valid ? tbl[rd.idx] : '0;
      end
      last_idx = rd.idx;
      last_req = rd.req;
    end
  end

  function automatic logic [RW+NUM_CNT-1:0] expect_result();
    logic [RW-1:0]      c = '0;
    logic [NUM_CNT-1:0] e = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (silent[k]) e[k] = 1'b1;
      else           c[k*CNT_W +: CNT_W] = tbl[k];
    end
    return {e, c};
  endfunction

  function automatic int expect_lat();
    int l = 0;
    for (int k = 0; k < NUM_CNT; k++) l += silent[k] ? (1 + TIMEOUT) : 2;
    return l;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin
    if (busy && rd.idx == 3'd2) idx2_cycles++;
    if (done) begin
      done_cnt++;
      check("sb_pending", 32'(exp_q.size()), 32'(1));
      if (exp_q.size() != 0) check("sb_result", 32'({err, cnt_all}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge CLK);
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_idx(input logic [IDX_W-1:0] target, input string tag);
    int k;
    for (k = 0; k < 40; k++) begin
      if (busy && rd.idx == target) break;
      @(negedge CLK);
    end
    check(tag, 32'(rd.idx), 32'(target));
  endtask

  task automatic set_table(input int base, input int mul);
    for (int k = 0; k < NUM_CNT; k++) tbl[k] = CNT_W'(base + mul * k);
  endtask

  task automatic run_full(input string tag);
    int lat, d0;
    exp_q.push_back(expect_result());
    d0 = done_cnt;
    pulse_start();
    check({tag, "_e0_req"},  32'(rd.req), 32'(1));
    check({tag, "_e0_busy"}, 32'(busy), 32'(1));
    check({tag, "_e0_idx"},  32'(rd.idx), 32'(0));
    check({tag, "_e0_clr"},  32'({err, cnt_all}), 32'(0));
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(expect_lat()));
    check({tag, "_done_busy"}, 32'(busy), 32'(0));
    repeat (3) @(negedge CLK);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'(1));
    check({tag, "_idle_req"}, 32'(rd.req), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, d0;
    logic [RW-1:0] part;

    set_table(3, 1);
    repeat (3) @(negedge CLK);
    check("rst_req",   32'(rd.req), 32'(0));
    check("rst_idx",   32'(rd.idx), 32'(0));
    check("rst_flags", 32'({busy, done, abort}), 32'(0));
    check("rst_data",  32'({err, cnt_all}), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(0));
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst_idle", 32'({rd.req, busy}), 32'(0));

    // counts idx+3, valid one cycle after each idx change
    run_full("basic");

    // silent slot 2, others 31
    set_table(31, 0);
    silent = 5'b00100;
    idx2_cycles = 0;
    run_full("silent");
    check("silent_slot2_cycles", 32'(idx2_cycles), 32'(1 + TIMEOUT));
    silent = '0;

    // stale valid: slot 1 must stay empty through its SETTLE edge
    set_table(1, 5);
    stale = 1'b1;
    exp_q.push_back(expect_result());
    pulse_start();
    wait_idx(3'd1, "stale_reach_idx1");
    @(negedge CLK);
    check("stale_settle_slot1", 32'(cnt_all[CNT_W +: CNT_W]), 32'(0));
    @(negedge CLK);
    check("stale_wait_slot1", 32'(cnt_all[CNT_W +: CNT_W]), 32'(tbl[1]));
    wait_done(lat);
    check("stale_latency", 32'(lat), 32'(6));
    stale = 1'b0;
    repeat (2) @(negedge CLK);

    // abort during WAIT for idx 3, landing on the same edge as valid
    set_table(3, 1);
    d0 = done_cnt;
    pulse_start();
    wait_idx(3'd3, "abort_reach_idx3");
    @(negedge CLK);
    IDLE = 1'b0;
    @(negedge CLK);
    part = '0;
    for (int k = 0; k < 3; k++) part[k*CNT_W +: CNT_W] = tbl[k];
    check("abort_pulse", 32'(abort), 32'(1));
    check("abort_req",   32'({rd.req, busy}), 32'(0));
    check("abort_keep",  32'({err, cnt_all}), 32'(part));
    @(negedge CLK);
    check("abort_one_cycle", 32'(abort), 32'(0));
    repeat (3) @(negedge CLK);
    check("abort_no_done", 32'(done_cnt - d0), 32'(0));
    IDLE = 1'b1;
    run_full("restart");

    // asynchronous reset mid-readout at idx 1
    pulse_start();
    wait_idx(3'd1, "rst_reach_idx1");
    #2 reset = 1'b0;
    #1;
    check("arst_req",   32'(rd.req), 32'(0));
    check("arst_idx",   32'(rd.idx), 32'(0));
    check("arst_flags", 32'({busy, done, abort}), 32'(0));
    check("arst_data",  32'({err, cnt_all}), 32'(0));
    IDLE = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check("noidle_start_req", 32'({rd.req, busy}), 32'(0));
      @(negedge CLK);
    end
    IDLE = 1'b1;
    repeat (2) @(negedge CLK);

    // start pulses while busy and while in S_DONE
    set_table(3, 1);
    exp_q.push_back(expect_result());
    d0 = done_cnt;
    pulse_start();
    lat = -1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge CLK);
      start = (k == 3);
      if (done) begin
        lat = k;
        start = 1'b1;
        break;
      end
    end
    @(negedge CLK);
    start = 1'b0;
    check("busy_start_latency", 32'(lat), 32'(10));
    for (int k = 0; k < 4; k++) begin
      check("done_start_ignored", 32'({rd.req, busy}), 32'(0));
      @(negedge CLK);
    end
    check("done_start_single", 32'(done_cnt - d0), 32'(1));

    // randomized tables and silence masks
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NUM_CNT; k++) tbl[k] = CNT_W'($urandom_range(0, 31));
      silent = NUM_CNT'($urandom_range(0, 31));
      run_full("rand");
    end
    silent = '0;

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
